// File: rtl/vertical_zoom_line_store.sv
// Vertical zoom stage: circular line store feeding a replicate/decimate read FSM.
// States: IDLE wait for a line | READ stream slot rd_ptr | SKIP drop a decimated line | RELEASE free slot, step group
module vertical_zoom_line_store #(
  parameter int PIXEL_W     = 8,
  parameter int IMAGE_WIDTH = 4,
  parameter int NUM_LINES   = 3,
  parameter int MAX_FACTOR  = 4,
  localparam int FW = $clog2(MAX_FACTOR + 1),
  localparam int FL = $clog2(NUM_LINES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [FW-1:0]      factor,
  input  logic [PIXEL_W-1:0] pixel_in,
  input  logic               pixel_valid_in,
  output logic               pixel_ready_out,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic               pixel_valid_out,
  input  logic               pixel_ready_in,
  output logic               line_end_out,
  output logic [FL-1:0]      lines_stored
);
  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int PW = $clog2(NUM_LINES);
  localparam logic [CW-1:0] COL_LAST   = CW'(IMAGE_WIDTH - 1);
  localparam logic [PW-1:0] PTR_LAST   = PW'(NUM_LINES - 1);
  localparam logic [FL-1:0] STORE_FULL = FL'(NUM_LINES);
  localparam logic [FW-1:0] F_MAX      = FW'(MAX_FACTOR);
  localparam logic [FW-1:0] F_ONE      = FW'(1);
  localparam logic [1:0]    MODE_BYP   = 2'b00;
  localparam logic [1:0]    MODE_IN    = 2'b01;
  localparam logic [1:0]    MODE_OUT   = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, SKIP, RELEASE} state_t;
  state_t state, state_nxt;

  logic [PIXEL_W-1:0] mem [NUM_LINES][IMAGE_WIDTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      wr_col, rd_col;
  logic [FL-1:0]      stored_nxt;
  logic [1:0]         eff_mode, req_mode, idle_mode, rel_mode;
  logic [FW-1:0]      eff_f, req_f, pass, grp_cnt, grp_nxt;
  logic               wr_fire, commit, release_line, advance, issue, replay;
  logic               group_end, idle_emit, rel_emit;
  logic               s1_valid, s1_last;
  logic [PIXEL_W-1:0] s1_data;

  assign pixel_ready_out = (lines_stored < STORE_FULL);
  assign wr_fire         = pixel_valid_in && pixel_ready_out;
  assign commit          = wr_fire && (wr_col == COL_LAST);
  assign release_line    = (state == RELEASE);
  assign advance         = !pixel_valid_out || pixel_ready_in;

  always_comb begin
    req_mode = (mode == 2'b11) ? MODE_BYP : mode;
    req_f    = factor;
    if (factor == '0)
      req_f = F_ONE;
    else if (factor > F_MAX)
      req_f = F_MAX;
    if (req_mode == MODE_BYP)
      req_f = F_ONE;
  end

  always_comb begin
    stored_nxt = lines_stored;
    if (commit && !release_line)
      stored_nxt = lines_stored + 1'b1;
    else if (!commit && release_line)
      stored_nxt = lines_stored - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      wr_col       <= '0;
      lines_stored <= '0;
    end else begin
      lines_stored <= stored_nxt;
      if (wr_fire) begin
        if (wr_col == COL_LAST) begin
          wr_col <= '0;
          wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wr_ptr][wr_col] <= pixel_in;
    if (issue)
      s1_data <= mem[rd_ptr][rd_col];
  end

  // Group position decides emit vs drop; a new group picks up the live mode/factor.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    replay    = (eff_mode == MODE_IN) && ((pass + 1'b1) < eff_f);
    group_end = (eff_mode != MODE_OUT) || ((grp_cnt + 1'b1) >= eff_f);
    grp_nxt   = group_end ? '0 : grp_cnt + 1'b1;
    idle_mode = (grp_cnt == '0) ? req_mode : eff_mode;
    idle_emit = (idle_mode != MODE_OUT) || (grp_cnt == '0);
    rel_mode  = group_end ? req_mode : eff_mode;
    rel_emit  = (rel_mode != MODE_OUT) || (grp_nxt == '0);
    case (state)
      IDLE: begin
        if (lines_stored != '0) begin
          state_nxt = idle_emit ? READ : SKIP;
          issue     = idle_emit && advance;
        end
      end
      READ: begin
        if (advance) begin
          issue = 1'b1;
          if (rd_col == COL_LAST && !replay)
            state_nxt = RELEASE;
        end
      end
      SKIP:    state_nxt = RELEASE;
      RELEASE: begin
        if (stored_nxt == '0)
          state_nxt = IDLE;
        else
          state_nxt = rel_emit ? READ : SKIP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      rd_col   <= '0;
      pass     <= '0;
      grp_cnt  <= '0;
      eff_mode <= MODE_BYP;
      eff_f    <= F_ONE;
    end else begin
      state <= state_nxt;
      if (state == IDLE && lines_stored != '0 && grp_cnt == '0) begin
        eff_mode <= req_mode;
        eff_f    <= req_f;
      end
      if (issue) begin
        if (rd_col == COL_LAST) begin
          rd_col <= '0;
          if (replay)
            pass <= pass + 1'b1;
        end else begin
          rd_col <= rd_col + 1'b1;
        end
      end
      if (release_line) begin
        rd_ptr  <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
        pass    <= '0;
        grp_cnt <= grp_nxt;
        if (group_end) begin
          eff_mode <= req_mode;
          eff_f    <= req_f;
        end
      end
    end
  end

  // Two-stage read pipe stalls as a whole, so the output holds while valid && !ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid        <= 1'b0;
      s1_last         <= 1'b0;
      pixel_out       <= '0;
      pixel_valid_out <= 1'b0;
      line_end_out    <= 1'b0;
    end else if (advance) begin
      s1_valid        <= issue;
      s1_last         <= (rd_col == COL_LAST);
      pixel_valid_out <= s1_valid;
      line_end_out    <= s1_valid && s1_last;
      if (s1_valid)
        pixel_out <= s1_data;
    end
  end
endmodule

// File: tb/tb_vertical_zoom_line_store.sv
// Scoreboard bench for vertical_zoom_line_store: expected pixels queued at send time, compared on output handshakes.
module tb_vertical_zoom_line_store;
  localparam int PIXEL_W     = 8;
  localparam int IMAGE_WIDTH = 4;
  localparam int NUM_LINES   = 3;
  localparam int MAX_FACTOR  = 4;
  localparam int FW          = $clog2(MAX_FACTOR + 1);
  localparam int FL          = $clog2(NUM_LINES + 1);
  localparam int BUDGET      = 2000;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         mode;
  logic [FW-1:0]      factor;
  logic [PIXEL_W-1:0] pixel_in;
  logic               pixel_valid_in;
  logic               pixel_ready_out;
  logic [PIXEL_W-1:0] pixel_out;
  logic               pixel_valid_out;
  logic               pixel_ready_in;
  logic               line_end_out;
  logic [FL-1:0]      lines_stored;

  logic [PIXEL_W:0] exp_q[$];
  int n_vec = 0, n_miscmp = 0, n_out = 0;

  vertical_zoom_line_store #(
    .PIXEL_W(PIXEL_W), .IMAGE_WIDTH(IMAGE_WIDTH), .NUM_LINES(NUM_LINES), .MAX_FACTOR(MAX_FACTOR)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .factor(factor),
    .pixel_in(pixel_in), .pixel_valid_in(pixel_valid_in), .pixel_ready_out(pixel_ready_out),
    .pixel_out(pixel_out), .pixel_valid_out(pixel_valid_out), .pixel_ready_in(pixel_ready_in),
    .line_end_out(line_end_out), .lines_stored(lines_stored)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference: bypass 1x, zoom-in replicates clamp(factor) times.
  task automatic expect_line(input logic [7:0] base, input logic [7:0] step, input int reps);
    logic [7:0] v;
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < IMAGE_WIDTH; i++) begin
        v = base + 8'(i) * step;
        exp_q.push_back({(i == IMAGE_WIDTH - 1), v});
      end
  endtask

  task automatic send_pix(input logic [7:0] v);
    int t;
    t = 0;
    pixel_in       = v;
    pixel_valid_in = 1'b1;
    while (!pixel_ready_out && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    if (t >= BUDGET) chk_val("send_timeout", t, 0);
    @(negedge clk);
    pixel_valid_in = 1'b0;
  endtask

  task automatic send_line(input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < IMAGE_WIDTH; i++) send_pix(base + 8'(i) * step);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    chk_val("drain", exp_q.size(), 0);
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_out(input int target);
    int t;
    t = 0;
    while (n_out < target && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    if (t >= BUDGET) chk_val("wait_out_timeout", n_out, target);
  endtask

  always @(negedge clk) begin
    #1;
    if (!rst && pixel_valid_out && pixel_ready_in) begin
      if (exp_q.size() == 0) chk_val("spurious_out", exp_q.size(), 1);
      else chk_val("pixel", {line_end_out, pixel_out}, exp_q.pop_front());
      n_out++;
    end
  end

  initial begin
    int base;
    rst = 1'b1; mode = 2'b00; factor = '0;
    pixel_in = '0; pixel_valid_in = 1'b0; pixel_ready_in = 1'b1;
    repeat (2) @(negedge clk);
    chk_val("rst_pixel", pixel_out, 0);
    chk_val("rst_valid", pixel_valid_out, 0);
    chk_val("rst_line_end", line_end_out, 0);
    chk_val("rst_stored", lines_stored, 0);
    chk_val("rst_ready", pixel_ready_out, 1);
    rst = 1'b0;
    @(negedge clk);

    // bypass, two lines
    expect_line(8'd1, 8'd1, 1);
    expect_line(8'd5, 8'd1, 1);
    send_line(8'd1, 8'd1);
    send_line(8'd5, 8'd1);
    drain();
    chk_val("t1_stored", lines_stored, 0);

    // zoom-in x3, with first-pixel latency and late release
    mode = 2'b01; factor = 3'd3;
    base = n_out;
    expect_line(8'd10, 8'd10, 3);
    send_line(8'd10, 8'd10);
    chk_val("t2_lat0", pixel_valid_out, 0);
    @(negedge clk);
    chk_val("t2_lat1", pixel_valid_out, 0);
    @(negedge clk);
    chk_val("t2_lat2", pixel_valid_out, 1);
    chk_val("t2_first", pixel_out, 10);
    wait_out(base + 8);
    chk_val("t2_held", lines_stored, 1);
    drain();
    chk_val("t2_stored", lines_stored, 0);

    // zoom-out /2: A and C kept
    mode = 2'b10; factor = 3'd2;
    expect_line(8'hA0, 8'd1, 1);
    expect_line(8'hC0, 8'd1, 1);
    send_line(8'hA0, 8'd1);
    send_line(8'hB0, 8'd1);
    send_line(8'hC0, 8'd1);
    send_line(8'hD0, 8'd1);
    drain();
    chk_val("t3_stored", lines_stored, 0);

    // full store under backpressure
    pixel_ready_in = 1'b0; mode = 2'b01; factor = 3'd4;
    expect_line(8'h10, 8'd1, 4);
    expect_line(8'h20, 8'd1, 4);
    expect_line(8'h30, 8'd1, 4);
    expect_line(8'h40, 8'd1, 4);
    send_line(8'h10, 8'd1);
    send_line(8'h20, 8'd1);
    send_line(8'h30, 8'd1);
    repeat (3) @(negedge clk);
    chk_val("t4_ready", pixel_ready_out, 0);
    chk_val("t4_stored", lines_stored, 3);
    chk_val("t4_stall_valid", pixel_valid_out, 1);
    pixel_ready_in = 1'b1;
    send_line(8'h40, 8'd1);
    drain();
    chk_val("t4_stored_end", lines_stored, 0);

    // factor clamping and mid-line factor change
    mode = 2'b01; factor = 3'd0;
    expect_line(8'h50, 8'd1, 1);
    send_line(8'h50, 8'd1);
    drain();
    factor = 3'd7;
    expect_line(8'h60, 8'd1, 4);
    send_line(8'h60, 8'd1);
    drain();
    factor = 3'd2;
    base = n_out;
    expect_line(8'h70, 8'd1, 2);
    send_line(8'h70, 8'd1);
    wait_out(base + 1);
    factor = 3'd3;
    drain();
    expect_line(8'h80, 8'd1, 3);
    send_line(8'h80, 8'd1);
    drain();
    chk_val("t5_stored", lines_stored, 0);

    // reset with output stalled and a partial input line
    pixel_ready_in = 1'b0; mode = 2'b00;
    expect_line(8'h90, 8'd1, 1);
    send_line(8'h90, 8'd1);
    send_pix(8'h99);
    send_pix(8'h9A);
    chk_val("t6_stalled", pixel_valid_out, 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk_val("t6_rst_pixel", pixel_out, 0);
    chk_val("t6_rst_valid", pixel_valid_out, 0);
    chk_val("t6_rst_line_end", line_end_out, 0);
    chk_val("t6_rst_stored", lines_stored, 0);
    @(negedge clk);
    rst = 1'b0;
    pixel_ready_in = 1'b1;
    @(negedge clk);
    expect_line(8'd5, 8'd1, 1);
    send_line(8'd5, 8'd1);
    drain();
    chk_val("t6_stored", lines_stored, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
